fetch_ctrl: RTL and testbench

Multi-cycle sequencer for the instruction-fetch stage. It drives the fetch stage's PC-load-enable, PC-select and branch-immediate inputs, and gates the instruction register. It handshakes with the execute/writeback side through a single done strobe. One instruction is in flight at a time: fetch, latch, execute, PC update, repeat.

---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Handshake/bus bundle between the fetch sequencer and the fetch/execute datapath.
// master: the sequencer (fetch_ctrl); slave: the datapath / execute side.
interface fetch_ctrl_if;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned WORD_W = 32;

    logic              exec_done;
    logic              branch_taken;
    logic [OFF_W-1:0]  branch_offset;
    logic              halt;
    logic              pc_ld_en;
    logic              pc_sel;
    logic [WORD_W-1:0] pc_immed;
    logic              ir_ld_en;
    logic              instr_valid;
    logic              halted;
    logic [WORD_W-1:0] retired_cnt;
    logic [WORD_W-1:0] taken_cnt;

    modport master (
        input  exec_done, branch_taken, branch_offset, halt,
        output pc_ld_en, pc_sel, pc_immed, ir_ld_en, instr_valid, halted,
               retired_cnt, taken_cnt
    );

    modport slave (
        output exec_done, branch_taken, branch_offset, halt,
        input  pc_ld_en, pc_sel, pc_immed, ir_ld_en, instr_valid, halted,
               retired_cnt, taken_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: RESET_WAIT -> FETCH -> LATCH -> EXEC -> UPDATE -> FETCH ...
// One instruction in flight; all outputs are registered copies of next-state decodes.
// Optional feature macro: FETCH_PERF_CNT_EN builds the retired/taken-branch counters;
// without it retired_cnt and taken_cnt are tied to 0.
module fetch_ctrl #(
    parameter int unsigned RESET_HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        S_RESET_WAIT,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_UPDATE,
        S_HALTED
    } state_t;

    state_t              state, state_nx;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
    logic                capture_c;

    logic                pc_ld_en_q, pc_sel_q, ir_ld_en_q, instr_valid_q, halted_q;
    logic                pc_ld_en_nx, pc_sel_nx, ir_ld_en_nx, instr_valid_nx, halted_nx;
    logic [WORD_W-1:0]   pc_immed_q, pc_immed_nx;

    // Next-state, capture decode and next output values
    always_comb begin
        state_nx       = state;
        hold_cnt_nx    = hold_cnt;
        capture_c      = 1'b0;
        pc_immed_nx    = pc_immed_q;

        case (state)
            S_RESET_WAIT: begin
                if (hold_cnt == HOLD_W'(RESET_HOLD)) begin
                    state_nx    = S_FETCH;
                    hold_cnt_nx = '0;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            S_FETCH:  state_nx = S_LATCH;
            S_LATCH:  state_nx = S_EXEC;
            S_EXEC: begin
                if (bus.exec_done) begin
                    capture_c   = 1'b1;
                    pc_immed_nx = {{14{bus.branch_offset[15]}}, bus.branch_offset, 2'b00};
                    state_nx    = bus.halt ? S_HALTED : S_UPDATE;
                end
            end
            S_UPDATE: state_nx = S_FETCH;
            S_HALTED: state_nx = S_HALTED;
            default:  state_nx = S_RESET_WAIT;
        endcase

        // Moore outputs decoded from the state being entered, then registered
        pc_ld_en_nx    = (state_nx == S_UPDATE);
        pc_sel_nx      = capture_c && !bus.halt && bus.branch_taken;
        ir_ld_en_nx    = (state_nx == S_LATCH);
        instr_valid_nx = (state_nx == S_EXEC);
        halted_nx      = (state_nx == S_HALTED);
    end

    // State, hold counter, captured offset and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_RESET_WAIT;
            hold_cnt      <= '0;
            pc_immed_q    <= '0;
            pc_ld_en_q    <= 1'b0;
            pc_sel_q      <= 1'b0;
            ir_ld_en_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state         <= state_nx;
            hold_cnt      <= hold_cnt_nx;
            pc_immed_q    <= pc_immed_nx;
            pc_ld_en_q    <= pc_ld_en_nx;
            pc_sel_q      <= pc_sel_nx;
            ir_ld_en_q    <= ir_ld_en_nx;
            instr_valid_q <= instr_valid_nx;
            halted_q      <= halted_nx;
        end
    end

    assign bus.pc_ld_en    = pc_ld_en_q;
    assign bus.pc_sel      = pc_sel_q;
    assign bus.pc_immed    = pc_immed_q;
    assign bus.ir_ld_en    = ir_ld_en_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [WORD_W-1:0] retired_q, taken_q;

    // Retired counts every capture (halting included); taken excludes halting captures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            taken_q   <= '0;
        end else if (capture_c) begin
            retired_q <= retired_q + WORD_W'(1);
            if (bus.branch_taken && !bus.halt) begin
                taken_q <= taken_q + WORD_W'(1);
            end
        end
    end

    assign bus.retired_cnt = retired_q;
    assign bus.taken_cnt   = taken_q;
`else
    assign bus.retired_cnt = '0;
    assign bus.taken_cnt   = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (RESET_HOLD = 1).
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_HOLD(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {pc_ld_en, pc_sel, ir_ld_en, instr_valid, halted}
    localparam logic [4:0] O_NONE = 5'b00000;
    localparam logic [4:0] O_IR   = 5'b00100;
    localparam logic [4:0] O_IV   = 5'b00010;
    localparam logic [4:0] O_UPD  = 5'b10000;
    localparam logic [4:0] O_BR   = 5'b11000;
    localparam logic [4:0] O_HALT = 5'b00001;

    function automatic logic [4:0] outs();
        return {bus.pc_ld_en, bus.pc_sel, bus.ir_ld_en, bus.instr_valid, bus.halted};
    endfunction

    function automatic logic [31:0] cnt(input int unsigned n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic [4:0] exp);
        tick();
        chk(tag, 32'(outs()), 32'(exp));
    endtask

    task automatic chk_cnts(input string tag, input int unsigned ret, input int unsigned tkn);
        chk({tag, "_ret"}, bus.retired_cnt, cnt(ret));
        chk({tag, "_tkn"}, bus.taken_cnt, cnt(tkn));
    endtask

    logic [4:0] seq_tied [12];
    logic [4:0] seq_boot [4];

    initial begin
        seq_tied = '{O_NONE, O_NONE, O_IR, O_IV, O_UPD, O_NONE,
                     O_IR, O_IV, O_UPD, O_NONE, O_IR, O_IV};
        seq_boot = '{O_NONE, O_NONE, O_IR, O_IV};

        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0000;
        bus.halt          = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", 32'(outs()), 32'(O_NONE));
        chk("rst_immed", bus.pc_immed, 32'h0);
        chk_cnts("rst", 0, 0);

        // Exec_done tied high: 4-cycle instruction period, PC+4 updates
        rst           = 1'b0;
        bus.exec_done = 1'b1;
        for (int i = 0; i < 12; i++) step_chk($sformatf("tied_%0d", i), seq_tied[i]);
        chk_cnts("tied", 2, 0);

        // Exec_done withheld: instr_valid holds 10 cycles total, no strobes
        bus.exec_done = 1'b0;
        for (int i = 0; i < 9; i++) step_chk($sformatf("stall_%0d", i), O_IV);

        // Backward taken branch
        bus.exec_done     = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'hFFFE;
        step_chk("br_neg", O_BR);
        chk("br_neg_immed", bus.pc_immed, 32'hFFFFFFF8);
        chk_cnts("br_neg", 3, 1);

        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0000;
        step_chk("fetch", O_NONE);

        // Pulses during LATCH are ignored
        bus.exec_done     = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'h0003;
        step_chk("latch_ign", O_IR);
        chk("latch_ign_immed", bus.pc_immed, 32'hFFFFFFF8);
        chk_cnts("latch_ign", 3, 1);
        step_chk("exec2", O_IV);

        // Forward taken branch captured in EXEC
        step_chk("br_pos", O_BR);
        chk("br_pos_immed", bus.pc_immed, 32'h0000000C);
        chk_cnts("br_pos", 4, 2);

        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0000;
        step_chk("pre_halt_f", O_NONE);
        step_chk("pre_halt_l", O_IR);
        step_chk("pre_halt_e", O_IV);

        // Halt and branch together: halt wins, no PC update, taken not counted
        bus.exec_done    = 1'b1;
        bus.branch_taken = 1'b1;
        bus.halt         = 1'b1;
        step_chk("halt", O_HALT);
        chk_cnts("halt", 5, 2);
        bus.branch_taken = 1'b0;
        bus.halt         = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.exec_done = i[0];
            step_chk($sformatf("halted_%0d", i), O_HALT);
        end
        chk_cnts("halted", 5, 2);

        // Asynchronous reset clears everything without a clock edge
        rst = 1'b1;
        #2;
        chk("arst_outs", 32'(outs()), 32'(O_NONE));
        chk("arst_immed", bus.pc_immed, 32'h0);
        chk_cnts("arst", 0, 0);
        tick();

        // Restart, then reset mid-UPDATE
        rst               = 1'b0;
        bus.exec_done     = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_offset = 16'h1234;
        for (int i = 0; i < 4; i++) step_chk($sformatf("boot_a_%0d", i), seq_boot[i]);
        step_chk("upd_pre_rst", O_BR);
        chk("upd_pre_rst_immed", bus.pc_immed, 32'h000048D0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_upd_outs", 32'(outs()), 32'(O_NONE));
        chk("rst_upd_immed", bus.pc_immed, 32'h0);
        chk_cnts("rst_upd", 0, 0);
        tick();
        rst               = 1'b0;
        bus.exec_done     = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_offset = 16'h0000;
        for (int i = 0; i < 4; i++) step_chk($sformatf("boot_b_%0d", i), seq_boot[i]);

        // Retired counter wrap from 32'hFFFFFFFE
`ifdef FETCH_PERF_CNT_EN
        force dut.retired_q = 32'hFFFFFFFE;
        #1;
        release dut.retired_q;
`endif
        bus.exec_done = 1'b1;
        step_chk("wrap_upd1", O_UPD);
        chk("wrap_ret1", bus.retired_cnt, PERF ? 32'hFFFFFFFF : 32'h0);
        step_chk("wrap_f", O_NONE);
        step_chk("wrap_l", O_IR);
        step_chk("wrap_e", O_IV);
        step_chk("wrap_upd2", O_UPD);
        chk("wrap_ret2", bus.retired_cnt, 32'h0);
        chk("wrap_tkn", bus.taken_cnt, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
